// File: rtl/cim_pkg.sv
// Shared constants, state encoding and helpers for the CIM bit-plane popcount front end.
package cim_pkg;

    localparam int unsigned ROWS  = 16;
    localparam int unsigned ABITS = 4;

    // Width needed to hold a count of 0..n inclusive.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned PSW = count_width(ROWS);
    localparam int unsigned BW  = (ABITS > 1) ? $clog2(ABITS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } state_t;

    typedef logic [ABITS-1:0]    act_row_t;
    typedef act_row_t [ROWS-1:0] act_vec_t;

    function automatic logic [PSW-1:0] popcount(input logic [ROWS-1:0] v);
        logic [PSW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            n = n + PSW'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cim_popcount_tree.sv
// Combinational N-input population count; shared with the multi-column array.
module cim_popcount_tree #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 5
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(N); i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/cim_bitplane_popcount.sv
// Serialises an activation vector MSB-plane first and emits the weighted,
// sparsity-gated popcount of each plane with first/last framing.
module cim_bitplane_popcount
    import cim_pkg::*;
(
    input  logic                  clk_1MHz,
    input  logic                  rst,
    input  logic                  w_load,
    input  logic [ROWS-1:0]       w_data,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [ROWS*ABITS-1:0] act_data,
    output logic [PSW-1:0]        partialSum,
    output logic                  ps_valid,
    output logic                  ps_first,
    output logic                  ps_last,
    output logic [PSW-1:0]        nz_count,
    output logic                  busy,
    output logic                  w_err
);

    state_t          state;
    logic [BW-1:0]   b;
    act_vec_t        act_reg;
    logic [ROWS-1:0] nz_mask;
    logic [ROWS-1:0] w_reg;

    act_vec_t        act_rows;
    logic            accept;
    logic            emit;
    logic [BW-1:0]   src_b;
    act_vec_t        src_act;
    logic [ROWS-1:0] src_nz;
    logic [ROWS-1:0] src_w;
    logic [ROWS-1:0] plane;
    logic [ROWS-1:0] gated;
    logic [PSW-1:0]  tree_count;

    assign act_rows  = act_data;
    assign act_ready = rst && ((state == IDLE) || (b == '0));
    assign accept    = act_valid && act_ready;

    // Select the plane driven onto the output register at the next edge:
    // either the MSB plane of a freshly accepted vector or the next stored plane.
    always_comb begin
        src_act = act_reg;
        src_nz  = nz_mask;
        src_w   = w_reg;
        src_b   = b - BW'(1);
        emit    = (state == SERIAL) && (b != '0);
        plane   = '0;
        if (accept) begin
            src_act = act_rows;
            src_w   = w_load ? w_data : w_reg;
            src_b   = BW'(ABITS - 1);
            emit    = 1'b1;
            for (int i = 0; i < int'(ROWS); i++) begin
                src_nz[i] = |act_rows[i];
            end
        end
        for (int i = 0; i < int'(ROWS); i++) begin
            plane[i] = src_act[i][src_b];
        end
        gated = src_w & src_nz & plane;
    end

    cim_popcount_tree #(
        .N(ROWS),
        .W(PSW)
    ) u_tree (
        .bits (gated),
        .count(tree_count)
    );

    always_ff @(posedge clk_1MHz or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            b          <= '0;
            act_reg    <= '0;
            nz_mask    <= '0;
            w_reg      <= '0;
            partialSum <= '0;
            ps_valid   <= 1'b0;
            ps_first   <= 1'b0;
            ps_last    <= 1'b0;
            nz_count   <= '0;
            busy       <= 1'b0;
            w_err      <= 1'b0;
        end else begin
            state    <= emit ? SERIAL : IDLE;
            busy     <= emit;
            ps_valid <= emit;
            if (emit) begin
                b          <= src_b;
                partialSum <= tree_count;
                ps_first   <= (src_b == BW'(ABITS - 1));
                ps_last    <= (src_b == '0);
            end else begin
                b          <= '0;
                partialSum <= '0;
                ps_first   <= 1'b0;
                ps_last    <= 1'b0;
            end
            if (accept) begin
                act_reg  <= act_rows;
                nz_mask  <= src_nz;
                nz_count <= popcount(src_nz);
            end
            // Weights may only change when no plane of an in-flight vector depends on them.
            if (w_load) begin
                if ((state == IDLE) || accept) begin
                    w_reg <= w_data;
                end else begin
                    w_err <= 1'b1;
                end
            end
        end
    end

endmodule
